// File: rtl/port_tx_arbiter.sv
// Arbitrates NUM_REQ packet streams onto one tx stream (round-robin or strict priority).
// Latency: grant registered one cycle after request in IDLE; data path is combinational.
// Backpressure: tx_ready passes straight to the owner's req_ready; over-long packets are cut and flushed.
module port_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BEATS = 188
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    prio_mode,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*64-1:0]   req_data,
    input  logic [NUM_REQ*8-1:0]    req_keep,
    input  logic [NUM_REQ-1:0]      req_last,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    tx_valid,
    output logic [63:0]             tx_data,
    output logic [7:0]              tx_keep,
    output logic                    tx_last,
    input  logic                    tx_ready,
    output logic [2:0]              grant_id,
    output logic                    busy,
    output logic [31:0]             tx_packet_count,
    output logic [31:0]             trunc_count
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {IDLE, XFER, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [31:0]     pkt_q, pkt_d;
    logic [31:0]     trunc_q, trunc_d;

    logic            sel_valid;
    logic            sel_last;
    logic [63:0]     sel_data;
    logic [7:0]      sel_keep;
    logic            force_last;
    logic            in_xfer;
    logic            in_flush;

    logic [IW-1:0]   win;
    int              win_best;
    int              win_dist;

    // Owner's signals, selected by the registered grant.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*64 +: 64];
                sel_keep  = req_keep[i*8 +: 8];
            end
        end
    end

    // Winner = smallest distance: rotated from last winner + 1, or the raw index in priority mode.
    always_comb begin
        win      = '0;
        win_best = NUM_REQ;
        win_dist = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
                if (prio_mode) begin
                    win_dist = i;
                end else begin
                    win_dist = (i + 2 * NUM_REQ - int'(rr_q) - 1) % NUM_REQ;
                end
                if (win_dist < win_best) begin
                    win_best = win_dist;
                    win      = IW'(i);
                end
            end
        end
    end

    assign force_last = (beat_q == BW'(MAX_BEATS - 1));
    assign in_xfer    = rst_n && (state_q == XFER);
    assign in_flush   = rst_n && (state_q == FLUSH);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        pkt_d   = pkt_q;
        trunc_d = trunc_q;
        case (state_q)
            IDLE: begin
                if (enable && (|req_valid)) begin
                    grant_d = win;
                    rr_d    = win;
                    beat_d  = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (sel_valid && tx_ready) begin
                    beat_d = beat_q + BW'(1);
                    if (sel_last) begin
                        pkt_d   = pkt_q + 32'd1;
                        state_d = IDLE;
                    end else if (force_last) begin
                        pkt_d   = pkt_q + 32'd1;
                        trunc_d = trunc_q + 32'd1;
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (sel_valid && sel_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= IW'(NUM_REQ - 1);
            beat_q  <= '0;
            pkt_q   <= '0;
            trunc_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
            pkt_q   <= pkt_d;
            trunc_q <= trunc_d;
        end
    end

    // Outputs are also gated by rst_n so nothing leaks while reset is held.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IW'(i)) begin
                req_ready[i] = (in_xfer && tx_ready) || in_flush;
            end
        end
    end

    assign tx_valid        = in_xfer && sel_valid;
    assign tx_data         = in_xfer ? sel_data : 64'd0;
    assign tx_keep         = in_xfer ? sel_keep : 8'd0;
    assign tx_last         = in_xfer && (sel_last || force_last);
    assign grant_id        = 3'(grant_q);
    assign busy            = rst_n && (state_q != IDLE);
    assign tx_packet_count = pkt_q;
    assign trunc_count     = trunc_q;

endmodule

// File: tb/tb_port_tx_arbiter.sv
// Randomized scoreboard bench for port_tx_arbiter; a packet-level model predicts the tx beat stream.
module tb_port_tx_arbiter;

    localparam int N    = 4;
    localparam int MAXB = 188;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic            prio_mode;
    logic [N-1:0]    req_valid;
    logic [N*64-1:0] req_data;
    logic [N*8-1:0]  req_keep;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            tx_valid;
    logic [63:0]     tx_data;
    logic [7:0]      tx_keep;
    logic            tx_last;
    logic            tx_ready;
    logic [2:0]      grant_id;
    logic            busy;
    logic [31:0]     tx_packet_count;
    logic [31:0]     trunc_count;

    always #5 clk = ~clk;

    port_tx_arbiter #(.NUM_REQ(N), .MAX_BEATS(MAXB)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .prio_mode(prio_mode),
        .req_valid(req_valid), .req_data(req_data), .req_keep(req_keep),
        .req_last(req_last), .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_keep(tx_keep),
        .tx_last(tx_last), .tx_ready(tx_ready),
        .grant_id(grant_id), .busy(busy),
        .tx_packet_count(tx_packet_count), .trunc_count(trunc_count)
    );

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        f;
    } beat_t;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        int          g;
    } exp_t;

    beat_t    src_q[N][$];
    beat_t    pend_q[N][$];
    exp_t     exp_q[$];
    exp_t     mon_e;
    int       n_chk = 0;
    int       n_fail = 0;
    int       m_rr, m_pkts, m_trunc;
    int       ready_mode;
    bit       gap_en;
    logic [N-1:0] hs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_pkt(input int i, input int len);
        beat_t b;
        for (int n = 0; n < len; n++) begin
            b.d = {$urandom, $urandom};
            b.k = 8'($urandom_range(1, 255));
            b.l = (n == len - 1);
            b.f = (n == 0);
            src_q[i].push_back(b);
            pend_q[i].push_back(b);
        end
    endtask

    // Packet-level reference: pick an owner among requesters with pending packets, emit at most MAXB beats.
    task automatic model_run();
        int    w, idx, k;
        beat_t b;
        exp_t  e;
        while (1) begin
            w = -1;
            for (int j = 0; j < N; j++) begin
                idx = prio_mode ? j : (m_rr + 1 + j) % N;
                if (w < 0 && pend_q[idx].size() > 0) w = idx;
            end
            if (w < 0) break;
            m_rr = w;
            k = 0;
            do begin
                b = pend_q[w].pop_front();
                if (k < MAXB) begin
                    e.d = b.d;
                    e.k = b.k;
                    e.l = b.l || (k == MAXB - 1);
                    e.g = w;
                    exp_q.push_back(e);
                end
                k++;
            end while (!b.l);
            m_pkts++;
            if (k > MAXB) m_trunc++;
        end
    endtask

    task automatic drive();
        beat_t b;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                req_valid[i]          = b.f || !gap_en || ($urandom % 4 != 0);
                req_data[i*64 +: 64]  = b.d;
                req_keep[i*8 +: 8]    = b.k;
                req_last[i]           = b.l;
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = ($urandom % 3 != 0);
        endcase
    endtask

    task automatic step();
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) void'(src_q[i].pop_front());
        end
        drive();
    endtask

    function automatic bit src_pending();
        bit p = 0;
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) p = 1;
        return p;
    endfunction

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((src_pending() || busy || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d cycles required below %0d", name, n, budget);
        end
        chk({name, "_pkt_count"}, 64'(tx_packet_count), 64'(m_pkts));
        chk({name, "_trunc_count"}, 64'(trunc_count), 64'(m_trunc));
    endtask

    // Monitor: every accepted tx beat is compared with the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && tx_valid) begin
            chk("req_ready_mirror", 64'(req_ready), tx_ready ? 64'(1 << grant_id) : 64'd0);
            if (tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %0h from %0d, scoreboard empty", tx_data, grant_id);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("tx_data", tx_data, mon_e.d);
                    chk("tx_keep", 64'(tx_keep), 64'(mon_e.k));
                    chk("tx_last", 64'(tx_last), 64'(mon_e.l));
                    chk("grant_id", 64'(grant_id), 64'(mon_e.g));
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion required finish before 90000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, found, cnt, np, len;
        rst_n      = 1'b0;
        enable     = 1'b1;
        prio_mode  = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req_keep   = '0;
        req_last   = '0;
        tx_ready   = 1'b1;
        ready_mode = 0;
        gap_en     = 0;
        m_rr = N - 1; m_pkts = 0; m_trunc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy_during", 64'(busy), 64'd0);
        chk("rst_txvalid_during", 64'(tx_valid), 64'd0);
        chk("rst_reqready_during", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        chk("rst_grant", 64'(grant_id), 64'd0);
        chk("rst_pkt_count", 64'(tx_packet_count), 64'd0);
        chk("rst_trunc_count", 64'(trunc_count), 64'd0);

        // Round-robin: four requesters, 2-beat packets, expect 0,1,2,3,0 at 3 cycles each.
        add_pkt(0, 2); add_pkt(0, 2);
        for (int i = 1; i < N; i++) add_pkt(i, 2);
        model_run();
        drive();
        n = 0; found = -1;
        while (n < 100 && found < 0) begin
            step();
            n++;
            if (tx_packet_count == 32'(m_pkts)) found = n;
        end
        chk("rr_five_pkt_cycles", 64'(found), 64'd15);
        drain("rr", 200);

        // Strict priority with the same traffic: requester 0 drains first.
        prio_mode = 1'b1;
        add_pkt(0, 2); add_pkt(0, 2);
        for (int i = 1; i < N; i++) add_pkt(i, 2);
        model_run();
        drive();
        drain("prio", 200);
        prio_mode = 1'b0;

        // Over-long packet gets truncated and the tail flushed.
        add_pkt(2, 200);
        model_run();
        drive();
        drain("trunc", 800);

        // Toggling tx_ready during a 4-beat packet.
        ready_mode = 1;
        add_pkt(1, 4);
        model_run();
        drive();
        drain("toggle", 100);
        ready_mode = 0;

        // enable dropped mid-packet: packet finishes, nothing new is granted.
        add_pkt(1, 3);
        model_run();
        drive();
        step();
        step();
        enable = 1'b0;
        add_pkt(3, 2);
        model_run();
        drive();
        n = 0;
        while (busy && n < 50) begin step(); n++; end
        for (int c = 0; c < 10; c++) begin
            step();
            chk("en_low_busy", 64'(busy), 64'd0);
            chk("en_low_txvalid", 64'(tx_valid), 64'd0);
        end
        chk("en_low_pending", 64'(src_q[3].size()), 64'd2);
        enable = 1'b1;
        drain("enable", 100);

        // Reset on beat 3 of a 5-beat packet.
        add_pkt(2, 5);
        model_run();
        drive();
        cnt = 0; n = 0;
        while (cnt < 2 && n < 50) begin
            step();
            if (hs[2]) cnt++;
            n++;
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_txvalid", 64'(tx_valid), 64'd0);
        chk("mid_rst_reqready", 64'(req_ready), 64'd0);
        step();
        chk("mid_rst_beats_seen", 64'(exp_q.size()), 64'd3);
        rst_n = 1'b1;
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_grant", 64'(grant_id), 64'd0);
        chk("post_rst_pkt_count", 64'(tx_packet_count), 64'd0);
        chk("post_rst_trunc_count", 64'(trunc_count), 64'd0);
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            pend_q[i].delete();
        end
        m_rr = N - 1; m_pkts = 0; m_trunc = 0;
        for (int i = 0; i < N; i++) add_pkt(i, 1);
        model_run();
        drive();
        drain("after_rst", 100);

        // Randomized rounds: modes, gaps, backpressure and occasional over-long packets.
        gap_en = 1;
        for (int r = 0; r < 25; r++) begin
            prio_mode  = 1'($urandom % 2);
            ready_mode = $urandom_range(0, 2);
            for (int i = 0; i < N; i++) begin
                np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) begin
                    len = ($urandom % 20 == 0) ? $urandom_range(185, 195) : $urandom_range(1, 8);
                    add_pkt(i, len);
                end
            end
            model_run();
            drive();
            drain("random", 3000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
